// File: rtl/life_pkg.sv
// Shared definitions for the Game-of-Life board stepper.
//   DEF_ROWS / DEF_COLS : default board size
//   NBR_W               : width of a neighbour count (0..8)
//   life_state_t        : stepper FSM states
package life_pkg;
    localparam int DEF_ROWS = 8;
    localparam int DEF_COLS = 8;
    localparam int NBR_W    = 4;

    typedef enum logic [1:0] {
        IDLE,
        COMPUTE,
        COMMIT
    } life_state_t;
endpackage

// File: rtl/life_cell_rule.sv
// Combinational Game-of-Life rule for one cell.
//   nbrs      : the 8 neighbour cells (order irrelevant), 1 = live
//   self_live : current state of the cell
//   live_next : state in the next generation (birth on 3, survive on 2 or 3)
module life_cell_rule
    import life_pkg::*;
(
    input  logic [7:0] nbrs,
    input  logic       self_live,
    output logic       live_next
);
    logic [NBR_W-1:0] n;

    always_comb begin
        n = '0;
        for (int i = 0; i < 8; i++) begin
            n = n + NBR_W'(nbrs[i]);
        end
        live_next = (n == NBR_W'(3)) || (self_live && (n == NBR_W'(2)));
    end
endmodule

// File: rtl/life_board_stepper.sv
// Holds a ROWS x COLS Game-of-Life board and advances it one generation per
// accepted step request, evaluating one row per cycle into a shadow board and
// committing all rows at once.
//   clk, reset_n          : clock, async active-low reset
//   load_en/load_row/data : write one board row (idle only)
//   clear                 : zero the board (idle only)
//   step_req              : start one generation (idle only)
//   busy                  : step in progress (COMPUTE or COMMIT)
//   gen_done              : one-cycle pulse in the commit cycle
//   stable                : last commit left the board unchanged
//   generation            : committed generation count (wraps at 16 bits)
//   board_out             : bit r*COLS+c = cell (r,c)
module life_board_stepper
    import life_pkg::*;
#(
    parameter int ROWS = DEF_ROWS,
    parameter int COLS = DEF_COLS,
    parameter bit WRAP = 1'b0
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    load_en,
    input  logic [$clog2(ROWS)-1:0] load_row,
    input  logic [COLS-1:0]         load_data,
    input  logic                    clear,
    input  logic                    step_req,
    output logic                    busy,
    output logic                    gen_done,
    output logic                    stable,
    output logic [15:0]             generation,
    output logic [ROWS*COLS-1:0]    board_out
);
    localparam int ROW_W = $clog2(ROWS);
    localparam int BITS  = ROWS * COLS;

    life_state_t      state_q, state_d;
    logic [ROW_W-1:0] row_q;
    logic [BITS-1:0]  board_q, shadow_q;
    logic [15:0]      gen_q;
    logic             stable_q;

    logic [COLS-1:0]  row_up, row_mid, row_dn, row_next;
    logic [COLS+1:0]  up_x, mid_x, dn_x;
    logic             clear_go, load_go, step_go, last_row;

    // Row r of a board; rows outside the board read as dead.
    function automatic logic [COLS-1:0] board_row(input logic [BITS-1:0] b, input int r);
        board_row = '0;
        if (r >= 0 && r < ROWS) begin
            board_row = b[r*COLS +: COLS];
        end
    endfunction

    // Rows k-1, k, k+1 of the committed board around the row counter.
    always_comb begin
        int r, ru, rd;
        r  = int'(row_q);
        ru = r - 1;
        rd = r + 1;
        if (WRAP) begin
            if (ru < 0)     ru = ROWS - 1;
            if (rd >= ROWS) rd = 0;
        end
        row_up  = board_row(board_q, ru);
        row_mid = board_row(board_q, r);
        row_dn  = board_row(board_q, rd);
    end

    // Rows extended by one column each side so that cell c sees columns
    // c-1..c+1 at x[c], x[c+1], x[c+2]; the pad bits are the wrapped
    // columns or dead cells.
    assign up_x  = {WRAP ? row_up[0]  : 1'b0, row_up,  WRAP ? row_up[COLS-1]  : 1'b0};
    assign mid_x = {WRAP ? row_mid[0] : 1'b0, row_mid, WRAP ? row_mid[COLS-1] : 1'b0};
    assign dn_x  = {WRAP ? row_dn[0]  : 1'b0, row_dn,  WRAP ? row_dn[COLS-1]  : 1'b0};

    for (genvar c = 0; c < COLS; c++) begin : g_cell
        life_cell_rule u_rule (
            .nbrs      ({up_x[c], up_x[c+1], up_x[c+2],
                         mid_x[c],           mid_x[c+2],
                         dn_x[c], dn_x[c+1], dn_x[c+2]}),
            .self_live (mid_x[c+1]),
            .live_next (row_next[c])
        );
    end

    // One command per idle cycle, priority clear > load > step.
    assign clear_go = (state_q == IDLE) && clear;
    assign load_go  = (state_q == IDLE) && !clear && load_en;
    assign step_go  = (state_q == IDLE) && !clear && !load_en && step_req;
    assign last_row = (row_q == ROW_W'(ROWS - 1));

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (step_go)  state_d = COMPUTE;
            COMPUTE: if (last_row) state_d = COMMIT;
            COMMIT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            row_q    <= '0;
            board_q  <= '0;
            shadow_q <= '0;
            gen_q    <= '0;
            stable_q <= 1'b0;
        end else begin
            state_q <= state_d;

            if (step_go) begin
                row_q <= '0;
            end else if (state_q == COMPUTE) begin
                row_q <= row_q + 1'b1;
            end

            if (state_q == COMPUTE) begin
                shadow_q[int'(row_q)*COLS +: COLS] <= row_next;
            end

            if (clear_go) begin
                board_q <= '0;
            end else if (load_go) begin
                // Out-of-range row indices are a no-op but still consume the cycle.
                if (int'(load_row) < ROWS) begin
                    board_q[int'(load_row)*COLS +: COLS] <= load_data;
                end
            end else if (state_q == COMMIT) begin
                board_q  <= shadow_q;
                stable_q <= (shadow_q == board_q);
                gen_q    <= gen_q + 16'd1;
            end
        end
    end

    assign busy       = (state_q != IDLE);
    assign gen_done   = (state_q == COMMIT);
    assign stable     = stable_q;
    assign generation = gen_q;
    assign board_out  = board_q;
endmodule

// File: tb/tb_life_board_stepper.sv
// Bench for life_board_stepper: two 8x8 instances (WRAP=0 and WRAP=1) share
// the same stimulus; a cycle-level model of the board and step timing is
// compared against both every cycle, plus literal expectations per scenario.
module tb_life_board_stepper;
    localparam int R = 8;
    localparam int C = 8;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        load_en = 1'b0;
    logic [2:0]  load_row = '0;
    logic [7:0]  load_data = '0;
    logic        clear = 1'b0;
    logic        step_req = 1'b0;

    logic        busy0, done0, stable0, busy1, done1, stable1;
    logic [15:0] gen0, gen1;
    logic [63:0] board0, board1;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    bit run_chk = 1'b0;

    // model state, per wrap mode
    logic [63:0] exp_board [2];
    logic [15:0] exp_gen   [2];
    logic        exp_stable[2];
    int          remain = 0;

    always #5 clk = ~clk;

    life_board_stepper #(.ROWS(R), .COLS(C), .WRAP(1'b0)) dut0 (
        .clk(clk), .reset_n(reset_n), .load_en(load_en), .load_row(load_row),
        .load_data(load_data), .clear(clear), .step_req(step_req),
        .busy(busy0), .gen_done(done0), .stable(stable0),
        .generation(gen0), .board_out(board0));

    life_board_stepper #(.ROWS(R), .COLS(C), .WRAP(1'b1)) dut1 (
        .clk(clk), .reset_n(reset_n), .load_en(load_en), .load_row(load_row),
        .load_data(load_data), .clear(clear), .step_req(step_req),
        .busy(busy1), .gen_done(done1), .stable(stable1),
        .generation(gen1), .board_out(board1));

    // Next generation straight from the rules, cell by cell.
    function automatic logic [63:0] life_next(input logic [63:0] b, input bit wrap);
        logic [63:0] nx;
        nx = '0;
        for (int r = 0; r < R; r++) begin
            for (int c = 0; c < C; c++) begin
                int n;
                n = 0;
                for (int dr = -1; dr <= 1; dr++) begin
                    for (int dc = -1; dc <= 1; dc++) begin
                        int rr, cc;
                        if (dr == 0 && dc == 0) continue;
                        rr = r + dr;
                        cc = c + dc;
                        if (wrap) begin
                            rr = (rr + R) % R;
                            cc = (cc + C) % C;
                        end else if (rr < 0 || rr >= R || cc < 0 || cc >= C) begin
                            continue;
                        end
                        n += int'(b[rr*C+cc]);
                    end
                end
                nx[r*C+c] = (n == 3) || (b[r*C+c] && n == 2);
            end
        end
        return nx;
    endfunction

    // Model: idle commands act at once; an accepted step completes R+1 edges later.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            remain = 0;
            for (int w = 0; w < 2; w++) begin
                exp_board[w] = '0; exp_gen[w] = '0; exp_stable[w] = 1'b0;
            end
        end else if (remain == 0) begin
            if (clear) begin
                for (int w = 0; w < 2; w++) exp_board[w] = '0;
            end else if (load_en) begin
                for (int w = 0; w < 2; w++) exp_board[w][int'(load_row)*C +: C] = load_data;
            end else if (step_req) begin
                remain = R + 1;
            end
        end else begin
            remain--;
            if (remain == 0) begin
                for (int w = 0; w < 2; w++) begin
                    logic [63:0] nx;
                    nx = life_next(exp_board[w], w[0]);
                    exp_stable[w] = (nx == exp_board[w]);
                    exp_board[w]  = nx;
                    exp_gen[w]    = exp_gen[w] + 16'd1;
                end
            end
        end
    end

    task automatic cmp(input string name, input int w, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            if (errors < 40) $display("FAIL %s wrap%0d t=%0t got %h want %h", name, w, $time, got, want);
        end
    endtask

    task automatic lit(input string name, input logic [63:0] got, input logic [63:0] want);
        cmp(name, 0, got, want);
    endtask

    always @(negedge clk) begin
        if (run_chk) begin
            if (done0) done_cnt++;
            cmp("board",  0, board0, exp_board[0]);
            cmp("board",  1, board1, exp_board[1]);
            cmp("gen",    0, 64'(gen0), 64'(exp_gen[0]));
            cmp("gen",    1, 64'(gen1), 64'(exp_gen[1]));
            cmp("stable", 0, 64'(stable0), 64'(exp_stable[0]));
            cmp("stable", 1, 64'(stable1), 64'(exp_stable[1]));
            cmp("busy",   0, 64'(busy0), 64'(remain != 0));
            cmp("busy",   1, 64'(busy1), 64'(remain != 0));
            cmp("done",   0, 64'(done0), 64'(remain == 1));
            cmp("done",   1, 64'(done1), 64'(remain == 1));
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset_n = 1'b0;
        tick(2);
        reset_n = 1'b1;
        tick(1);
    endtask

    task automatic load(input int r, input logic [7:0] d);
        load_en = 1'b1; load_row = 3'(r); load_data = d;
        tick();
        load_en = 1'b0;
    endtask

    task automatic step;
        step_req = 1'b1;
        tick();
        step_req = 1'b0;
        tick(R + 1);
    endtask

    localparam logic [63:0] BLINK_H = 64'h0000_0000_1C00_0000;
    localparam logic [63:0] BLINK_V = 64'h0000_0008_0808_0000;
    localparam logic [63:0] BLOCK   = 64'h0000_0000_0006_0600;
    localparam logic [63:0] GLIDER  = 64'h0000_0000_0007_0402;

    initial begin
        int d0;
        #1 reset_n = 1'b0;
        do_reset();
        run_chk = 1'b1;

        // reset state
        lit("rst_board", board0, 64'h0);
        lit("rst_gen",   64'(gen1), 64'h0);
        lit("rst_busy",  64'(busy0), 64'h0);

        // 1: blinker, two steps back to back
        load(3, 8'b0001_1100);
        step();
        lit("blink1", board0, BLINK_V);
        step();
        lit("blink2", board0, BLINK_H);
        lit("blink_stable", 64'(stable0), 64'h0);
        lit("blink_gen", 64'(gen0), 64'd2);

        // 2: block still life, single gen_done pulse
        do_reset();
        load(1, 8'b0000_0110);
        load(2, 8'b0000_0110);
        d0 = done_cnt;
        step();
        lit("block_board", board0, BLOCK);
        lit("block_stable", 64'(stable0), 64'h1);
        lit("block_done_cnt", 64'(done_cnt - d0), 64'd1);

        // 3: lone corner cell dies in both modes; L-triomino wraps into (7,7)
        do_reset();
        load(0, 8'h01);
        step();
        lit("lone_w0", board0, 64'h0);
        lit("lone_w1", board1, 64'h0);
        do_reset();
        load(0, 8'b1000_0001);
        load(7, 8'b0000_0001);
        step();
        lit("tri_w1_77", 64'(board1[63]), 64'h1);
        lit("tri_w0_77", 64'(board0[63]), 64'h0);

        // 4: glider on the torus returns home after 32 generations
        do_reset();
        load(0, 8'b0000_0010);
        load(1, 8'b0000_0100);
        load(2, 8'b0000_0111);
        for (int i = 0; i < 32; i++) step();
        lit("glider_board", board1, GLIDER);
        lit("glider_gen", 64'(gen1), 64'd32);

        // 5a: commands during a step are dropped
        do_reset();
        load(3, 8'b0001_1100);
        step_req = 1'b1;
        tick();
        load_en = 1'b1; load_row = 3'd0; load_data = 8'hFF; clear = 1'b1;
        tick(3);
        step_req = 1'b0; load_en = 1'b0; clear = 1'b0;
        tick(R - 2);
        lit("busy_drop_board", board0, BLINK_V);
        lit("busy_drop_gen", 64'(gen0), 64'd1);
        tick(2);
        lit("busy_drop_idle", 64'(busy0), 64'h0);

        // 5b: reset in the middle of a step aborts it
        d0 = done_cnt;
        step_req = 1'b1;
        tick();
        step_req = 1'b0;
        tick(3);
        reset_n = 1'b0;
        tick();
        lit("abort_busy", 64'(busy0), 64'h0);
        lit("abort_board", board0, 64'h0);
        reset_n = 1'b1;
        tick(R + 2);
        lit("abort_no_done", 64'(done_cnt - d0), 64'd0);

        // 6: generation counter wraps; empty board is stable
        do_reset();
        force dut0.gen_q = 16'hFFFF;
        force dut1.gen_q = 16'hFFFF;
        exp_gen[0] = 16'hFFFF;
        exp_gen[1] = 16'hFFFF;
        tick();
        release dut0.gen_q;
        release dut1.gen_q;
        tick();
        lit("gen_preload", 64'(gen0), 64'hFFFF);
        step();
        lit("gen_wrap", 64'(gen0), 64'h0);
        lit("gen_wrap_stable", 64'(stable0), 64'h1);

        tick(2);
        run_chk = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
